// File: rtl/div_clk_monitor_if.sv
// Bundle of the monitor's measurement-control and report signals.
// master: the observer side (drives enable/div_in, reads the report).
// slave:  the monitor itself (reads enable/div_in, drives the report).
`timescale 1ns/1ps

interface div_clk_monitor_if #(
    parameter int CNT_W = 8,
    parameter int PER_W = 8
);
    logic             enable;      // measurement enable, synchronous to clk
    logic             div_in;      // divided clock under observation (async data)
    logic [CNT_W-1:0] edge_count;  // rising edges in the last completed window
    logic [PER_W-1:0] period;      // clk cycles between the last two rises
    logic             no_edge;     // last window / arm timeout saw no rise
    logic             freq_ok;     // last window matched the expected period
    logic             meas_valid;  // one-cycle strobe when the report updates

    modport master (
        output enable,
        output div_in,
        input  edge_count,
        input  period,
        input  no_edge,
        input  freq_ok,
        input  meas_valid
    );

    modport slave (
        input  enable,
        input  div_in,
        output edge_count,
        output period,
        output no_edge,
        output freq_ok,
        output meas_valid
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Purpose: counts rising edges of a divided clock over a GATE_LEN-cycle window and measures its period.
// Latency: div_in is seen 2 cycles late (synchroniser); one report per window, >= GATE_LEN+1 cycles apart.
// Backpressure: none; meas_valid is a one-cycle strobe and the report registers hold until the next report.
//
// Ports:
//   clk  - source clock, also the clock of the divider being observed
//   rst  - asynchronous active-low reset
//   mon  - div_clk_monitor_if.slave: enable/div_in in, edge_count/period/no_edge/freq_ok/meas_valid out
`timescale 1ns/1ps

module div_clk_monitor #(
    parameter int GATE_LEN   = 64,
    parameter int CNT_W      = 8,
    parameter int PER_W      = 8,
    parameter int EXP_PERIOD = 2
) (
    input  logic              clk,
    input  logic              rst,
    div_clk_monitor_if.slave  mon
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_REPORT  = 2'd3;

    // Index of the final cycle of a window / arm timeout.
    localparam logic [15:0]      LAST_CYC = 16'(GATE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PER_W-1:0] PER_MAX  = '1;
    localparam logic [PER_W-1:0] EXP_PER  = PER_W'(EXP_PERIOD);

    logic             sync1, sync2, sync3;
    logic             rise;
    logic [1:0]       state, state_nxt;
    logic [15:0]      arm_cnt;
    logic [15:0]      gate_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [PER_W-1:0] last_per;

    logic [CNT_W-1:0] edge_cnt_inc;
    logic [PER_W-1:0] per_cnt_inc;
    logic [CNT_W-1:0] meas_edge_nxt;
    logic [PER_W-1:0] meas_per_nxt;

    logic [CNT_W-1:0] edge_count_q;
    logic [PER_W-1:0] period_q;
    logic             no_edge_q;
    logic             freq_ok_q;

    // sync2 is the first metastability-safe copy; sync3 only exists to find the edge.
    assign rise = sync2 & ~sync3;

    // Saturating increments shared by the period and edge counters.
    assign edge_cnt_inc = (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + 1'b1;
    assign per_cnt_inc  = (per_cnt  == PER_MAX) ? per_cnt  : per_cnt  + 1'b1;

    // Counter values as they will stand after this MEASURE cycle, so a rise in
    // the final window cycle is already included when the report loads.
    assign meas_edge_nxt = rise ? edge_cnt_inc : edge_cnt;
    assign meas_per_nxt  = rise ? per_cnt_inc  : last_per;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mon.enable) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!mon.enable)              state_nxt = ST_IDLE;
                else if (rise)                state_nxt = ST_MEASURE;
                else if (arm_cnt == LAST_CYC) state_nxt = ST_REPORT;
            end
            ST_MEASURE: begin
                if (!mon.enable)               state_nxt = ST_IDLE;
                else if (gate_cnt == LAST_CYC) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                // A rise during the report cycle re-arms immediately.
                if (!mon.enable) state_nxt = ST_IDLE;
                else if (rise)   state_nxt = ST_MEASURE;
                else             state_nxt = ST_ARM;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            state        <= ST_IDLE;
            arm_cnt      <= '0;
            gate_cnt     <= '0;
            per_cnt      <= '0;
            edge_cnt     <= '0;
            last_per     <= '0;
            edge_count_q <= '0;
            period_q     <= '0;
            no_edge_q    <= 1'b0;
            freq_ok_q    <= 1'b0;
        end else begin
            sync1 <= mon.div_in;
            sync2 <= sync1;
            sync3 <= sync2;
            state <= state_nxt;

            case (state)
                ST_ARM: begin
                    arm_cnt  <= arm_cnt + 16'd1;
                    gate_cnt <= '0;
                    per_cnt  <= '0;
                    edge_cnt <= '0;
                    last_per <= '0;
                    // Arm timeout: report a dead divider.
                    if (state_nxt == ST_REPORT) begin
                        edge_count_q <= '0;
                        period_q     <= '0;
                        no_edge_q    <= 1'b1;
                        freq_ok_q    <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    arm_cnt  <= '0;
                    gate_cnt <= gate_cnt + 16'd1;
                    per_cnt  <= rise ? '0 : per_cnt_inc;
                    edge_cnt <= meas_edge_nxt;
                    last_per <= meas_per_nxt;
                    if (state_nxt == ST_REPORT) begin
                        edge_count_q <= meas_edge_nxt;
                        period_q     <= meas_per_nxt;
                        no_edge_q    <= (meas_edge_nxt == '0);
                        freq_ok_q    <= (meas_per_nxt == EXP_PER) && (meas_edge_nxt != '0);
                    end
                end
                default: begin
                    // IDLE and REPORT: start the next window from clean counters.
                    arm_cnt  <= '0;
                    gate_cnt <= '0;
                    per_cnt  <= '0;
                    edge_cnt <= '0;
                    last_per <= '0;
                end
            endcase
        end
    end

    assign mon.edge_count = edge_count_q;
    assign mon.period     = period_q;
    assign mon.no_edge    = no_edge_q;
    assign mon.freq_ok    = freq_ok_q;
    assign mon.meas_valid = (state == ST_REPORT);

endmodule
